// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for a raster pixel stream.
// Two line buffers hold the previous two image rows. A 3x3 pixel register
// slides one column per accepted pixel. The output is one packed window per
// valid (no padding, stride 1) position. Both sides are valid-only.
module conv_window_gen #(
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16,
    parameter int unsigned CH    = 3,
    localparam int unsigned CW   = $clog2(IMG_W),
    localparam int unsigned RW   = $clog2(IMG_H),
    localparam int unsigned PW   = CH * 8,
    localparam int unsigned WW   = 9 * CH * 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pix_valid_i,
    input  logic          pix_sof_i,
    input  logic [PW-1:0] pix_data_i,
    output logic          win_valid_o,
    output logic [WW-1:0] win_data_o,
    output logic [RW-1:0] win_row_o,
    output logic [CW-1:0] win_col_o,
    output logic          frame_done_o
);

    // Position of the next expected pixel
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          last_col, last_row, win_hit;

    // lb0 holds row r-2, lb1 holds row r-1 (indexed by column)
    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] lb0_rd, lb1_rd;

    // Window register indexed [row][col], row 0 = top, col 0 = left
    logic [PW-1:0] win_q [3][3];
    logic [PW-1:0] win_d [3][3];
    logic [WW-1:0] pack_d;

    // Resolve the accepted pixel's position and the next counter values
    always_comb begin
        cur_col  = pix_sof_i ? '0 : col_q;
        cur_row  = pix_sof_i ? '0 : row_q;
        last_col = (cur_col == CW'(IMG_W - 1));
        last_row = (cur_row == RW'(IMG_H - 1));
        win_hit  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        col_d    = cur_col + CW'(1);
        row_d    = cur_row;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : cur_row + RW'(1);
        end
    end

    // Line buffer read of the current column
    always_comb begin
        lb0_rd = lb0[cur_col];
        lb1_rd = lb1[cur_col];
    end

    // Shifted window and its packed form (channel-major, then row, then column)
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb0_rd;
        win_d[1][2] = lb1_rd;
        win_d[2][2] = pix_data_i;
        pack_d = '0;
        for (int c = 0; c < int'(CH); c++) begin
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    pack_d[(c * 9 + r * 3 + k) * 8 +: 8] = win_d[r][k][c * 8 +: 8];
                end
            end
        end
    end

    // Line buffers: no reset needed, rows 0-1 of a frame refill them before use
    always_ff @(posedge clk_i) begin
        if (pix_valid_i) begin
            lb0[cur_col] <= lb1_rd;
            lb1[cur_col] <= pix_data_i;
        end
    end

    // Counters, window register and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            win_data_o   <= '0;
            win_row_o    <= '0;
            win_col_o    <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    win_q[r][k] <= '0;
                end
            end
        end else begin
            win_valid_o  <= pix_valid_i && win_hit;
            frame_done_o <= pix_valid_i && win_hit && last_col && last_row;
            if (pix_valid_i) begin
                col_q <= col_d;
                row_q <= row_d;
                win_q <= win_d;
                // Output fields only update with a new window; otherwise hold
                if (win_hit) begin
                    win_data_o <= pack_d;
                    win_row_o  <= cur_row - RW'(2);
                    win_col_o  <= cur_col - CW'(2);
                end
            end
        end
    end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3x3 window generator that sits directly upstream of the 16-filter systolic convolution array. It accepts a raster-order pixel stream (3 channels x 8 bit), buffers the two previous image lines internally, and emits one packed 27-byte window per valid output position (no padding, stride 1). Its output word connects unchanged to the array's 216-bit activation input; the array has no backpressure, so this block is valid-only on both sides.

## Interface
- IMG_W, 16, image width in pixels (>= 3)
- IMG_H, 16, image height in pixels (>= 3)
- CH, 3, channels per pixel (fixed at 3; window width = 9*CH*8 = 216)
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- pix_valid_i  input  1  pixel present this cycle
- pix_sof_i  input  1  qualifies pixel as first of frame (row 0, col 0); ignored when pix_valid_i=0
- pix_data_i  input  24  channel c in bits [c*8 +: 8]
- win_valid_o  output  1  window present this cycle (one-cycle pulse per window)
- win_data_o  output  216  packed window
- win_row_o  output  clog2(IMG_H)  row of window's top-left pixel
- win_col_o  output  clog2(IMG_W)  column of window's top-left pixel
- frame_done_o  output  1  one-cycle pulse with the frame's last window

## Operation
- State: col/row counters of next expected pixel; two line buffers lb0 (row r-2), lb1 (row r-1), IMG_W x 24 bit each; 3x3 pixel window register.
- Accept: pixel taken on every edge with pix_valid_i=1; no ready, no stalls. pix_valid_i=0 holds all state.
- Position: if pix_sof_i=1, pixel is (0,0) regardless of counters; else pixel is (row,col) from counters.
- On accept at column c: window shifts one column left; new right column = {lb0[c], lb1[c], pix} (top to bottom); lb0[c] <= lb1[c]; lb1[c] <= pix.
- Counters: col increments; at col=IMG_W-1 col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0.
- Window valid when accepted pixel has row >= 2 and col >= 2; windows per frame = (IMG_W-2)*(IMG_H-2).
- Packing: win_data_o[(c*9 + r*3 + k)*8 +: 8], c = channel, r = window row (0 = top), k = window column (0 = left).
- win_row_o = row-2, win_col_o = col-2 of the completing pixel.
- Mid-frame pix_sof_i: current frame abandoned, no frame_done_o; line buffer contents are stale but are never exposed because rows 0-1 of the new frame overwrite them before any valid window.
- Frame with no sof: counters continue from wrap, so back-to-back frames need no sof.

## Timing
- Reset: win_valid_o=0, frame_done_o=0, win_data_o=0, win_row_o=0, win_col_o=0; counters 0; window register 0. Line buffers need not be reset.
- Latency: pixel accepted at edge t -> window containing it as bottom-right on outputs after edge t (visible in cycle t+1), win_valid_o high exactly that cycle.
- win_data_o/win_row_o/win_col_o hold their last value when win_valid_o=0.
- frame_done_o asserts in the same cycle as the window for pixel (IMG_H-1, IMG_W-1).
- Reset asserted mid-frame: outputs drop to reset values immediately (asynchronous); next accepted pixel after release is (0,0) even without sof.
- Throughput: one window per clock when pix_valid_i held high within rows 2..IMG_H-1, cols 2..IMG_W-1.

## Test plan
- IMG_W=IMG_H=4, pixel index p=row*4+col, channels {p, p+64, p+128}, continuous valid -> exactly 4 windows; first after pixel 10 with byte0=0, byte8=10, byte9=64, byte26=138; win_row_o/win_col_o=(0,0),(0,1),(1,0),(1,1); frame_done_o with the 4th.
- Same image with pix_valid_i toggled 1-0-1-0 -> identical window data/order, each win_valid_o one cycle after its completing pixel, no output on idle cycles.
- Two back-to-back 4x4 frames, sof only on the first -> 8 windows, two frame_done_o pulses, second frame data correct.
- pix_sof_i asserted at pixel 7 of a frame, then full 4x4 frame -> no frame_done_o for abandoned frame; next 4 windows match reference for new frame.
- rst_i pulsed after pixel 11 (mid-cycle) -> outputs 0 immediately; full frame afterwards without sof yields 4 correct windows.
- IMG_W=IMG_H=3 -> single window per frame with frame_done_o in same cycle, win_row_o=win_col_o=0.
